// File: rtl/ad_chan_avg.sv
// ad_chan_avg
// Frame averager for the twelve AD7266 channel results.
// Each rd_done snapshots all twelve 12-bit results. A single shared adder then
// walks the channels one per cycle, adding each into its accumulator. After
// 2^AVG_LOG2 frames the rounded averages are published together with a
// one-cycle avg_valid strobe.
//
// Ports:
//   sys_clk   - system clock
//   rst       - synchronous active-high reset
//   rd_done   - one-cycle pulse, chan_in valid in the same cycle
//   chan_in   - 12 x 12-bit packed results, slice i = channel i (A1,B1,A2,...,B6)
//   ovr_clr   - clears the sticky overrun flag
//   avg_out   - 12 x 12-bit averaged results, same packing, updated atomically
//   avg_valid - one-cycle pulse marking a new avg_out
//   busy      - high while a frame is being accumulated
//   overrun   - sticky; rd_done arrived while busy (that frame was dropped)
//   frame_idx - frames already accumulated in the current window
module ad_chan_avg #(
    parameter int AVG_LOG2 = 4
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         rd_done,
    input  logic [143:0] chan_in,
    input  logic         ovr_clr,
    output logic [143:0] avg_out,
    output logic         avg_valid,
    output logic         busy,
    output logic         overrun,
    output logic [7:0]   frame_idx
);

    localparam int AW = 12 + AVG_LOG2;
    localparam logic [8:0] LAST_FRAME = 9'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     idx_reg;
    logic [143:0]   snap_reg;
    logic [AW-1:0]  acc_reg [12];
    logic [11:0]    stage_reg [12];
    logic [143:0]   stage_flat;
    logic [AW-1:0]  sum;
    logic [11:0]    rounded;
    logic           last_frame;

    assign busy       = (state_reg != ST_IDLE);
    assign last_frame = ({1'b0, frame_idx} == LAST_FRAME);

    // The one shared adder; the accumulator is wide enough for 2^AVG_LOG2
    // full-scale samples, so it cannot overflow.
    assign sum = acc_reg[idx_reg] + AW'(snap_reg[idx_reg*12 +: 12]);

    // Round-half-up divide by 2^AVG_LOG2. The biased sum still fits in AW
    // bits because the worst case is 4095*2^L + 2^(L-1) < 2^(12+L).
    generate
        if (AVG_LOG2 == 0) begin : g_no_div
            assign rounded = sum;
        end else begin : g_div
            logic [AW-1:0] biased;
            assign biased  = sum + AW'(1 << (AVG_LOG2 - 1));
            assign rounded = 12'(biased >> AVG_LOG2);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_pack
            assign stage_flat[gi*12 +: 12] = stage_reg[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (rd_done) state_next = ST_ACC;
            ST_ACC:  if (idx_reg == 4'd11) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            idx_reg   <= '0;
            snap_reg  <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_idx <= '0;
            for (int i = 0; i < 12; i++) begin
                acc_reg[i]   <= '0;
                stage_reg[i] <= '0;
            end
        end else begin
            avg_valid <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (rd_done) begin
                        snap_reg <= chan_in;
                        idx_reg  <= '0;
                    end
                end
                ST_ACC: begin
                    // On the window's last frame the accumulator is emptied as
                    // its result is staged, so the next window starts clean.
                    if (last_frame) begin
                        stage_reg[idx_reg] <= rounded;
                        acc_reg[idx_reg]   <= '0;
                    end else begin
                        acc_reg[idx_reg] <= sum;
                    end
                    idx_reg <= idx_reg + 4'd1;
                end
                ST_DONE: begin
                    idx_reg <= '0;
                    if (last_frame) begin
                        avg_out   <= stage_flat;
                        avg_valid <= 1'b1;
                        frame_idx <= '0;
                    end else begin
                        frame_idx <= frame_idx + 8'd1;
                    end
                end
                default: idx_reg <= '0;
            endcase

            // Set has priority over clear.
            if (rd_done && busy) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
